// File: rtl/cnn_conv_seq_if.sv
// Sequencer <-> conv array / window fetcher bus: kernel configuration push,
// window position issue with fetcher/array back-pressure, and result-valid lanes.
interface cnn_conv_seq_if #(
    parameter int DIM_W       = 10,
    parameter int KERNEL_SIZE = 3,
    parameter int WEIGHT_SIZE = 4
);
    logic                   conf_refresh;
    logic [KERNEL_SIZE-1:0] kernel_height;
    logic [KERNEL_SIZE-1:0] kernel_width;
    logic                   act_valid;
    logic                   src_ready;
    logic [DIM_W-1:0]       win_row;
    logic [DIM_W-1:0]       win_col;
    logic                   window_valid;
    logic                   window_stall;
    logic [WEIGHT_SIZE-1:0] conv_valid;

    modport master (
        output conf_refresh, kernel_height, kernel_width, act_valid,
        output win_row, win_col, window_valid,
        input  src_ready, window_stall, conv_valid
    );

    modport slave (
        input  conf_refresh, kernel_height, kernel_width, act_valid,
        input  win_row, win_col, window_valid,
        output src_ready, window_stall, conv_valid
    );
endinterface

// File: rtl/cnn_conv_seq.sv
// CNN conv layer sequencer: validates a layer command, pushes kernel config, issues
// raster-order windows and waits for all results. CNN_CONV_SEQ_PERF_EN adds perf counters.
module cnn_conv_seq #(
    parameter int DIM_W       = 10,
    parameter int KERNEL_SIZE = 3,
    parameter int WEIGHT_SIZE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIM_W-1:0]       cfg_height,
    input  logic [DIM_W-1:0]       cfg_width,
    input  logic [KERNEL_SIZE-1:0] cfg_kernel,
    input  logic                   cfg_act,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    cnn_conv_seq_if.master         arr
`ifdef CNN_CONV_SEQ_PERF_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_stall
`endif
);
    localparam int CW = 2 * DIM_W;
    localparam logic [CW-1:0] ONE_W = CW'(1);

    typedef enum logic [2:0] {S_IDLE, S_CFG, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic                   prime_q, prime_d;
    logic [DIM_W-1:0]       row_q, row_d, col_q, col_d;
    logic [DIM_W-1:0]       lrow_q, lrow_d, lcol_q, lcol_d;
    logic [CW-1:0]          total_q, total_d, cnt_q, cnt_d;
    logic [KERNEL_SIZE-1:0] kern_q, kern_d;
    logic                   act_q, act_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d, refresh_q, refresh_d;

    logic             kern_ok, cfg_ok, accept, in_run, issue, res_inc;
    logic [DIM_W-1:0] kside, lrow_n, lcol_n;
    logic [CW-1:0]    n_total;

    always_comb begin
        kern_ok = 1'b1;
        kside   = '0;
        case (cfg_kernel)
            KERNEL_SIZE'(1): kside = DIM_W'(1);
            KERNEL_SIZE'(2): kside = DIM_W'(3);
            KERNEL_SIZE'(4): kside = DIM_W'(5);
            default:         kern_ok = 1'b0;
        endcase
    end

    assign cfg_ok  = kern_ok && (cfg_height >= kside) && (cfg_width >= kside);
    assign accept  = (state_q == S_IDLE) && start && cfg_ok;
    // last valid top-left index per axis, i.e. OH-1 and OW-1
    assign lrow_n  = cfg_height - kside;
    assign lcol_n  = cfg_width - kside;
    assign n_total = ({{DIM_W{1'b0}}, lrow_n} + ONE_W) * ({{DIM_W{1'b0}}, lcol_n} + ONE_W);

    assign in_run  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign issue   = (state_q == S_RUN) && arr.src_ready && !arr.window_stall;
    assign res_inc = in_run && arr.conv_valid[WEIGHT_SIZE-1] && !arr.window_stall;

    always_comb begin
        state_d = state_q;
        prime_d = prime_q;
        row_d   = row_q;
        col_d   = col_q;
        lrow_d  = lrow_q;
        lcol_d  = lcol_q;
        total_d = total_q;
        kern_d  = kern_q;
        act_d   = act_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, res_inc};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        kern_d  = cfg_kernel;
                        act_d   = cfg_act;
                        lrow_d  = lrow_n;
                        lcol_d  = lcol_n;
                        total_d = n_total;
                        row_d   = '0;
                        col_d   = '0;
                        cnt_d   = '0;
                        state_d = S_CFG;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CFG: begin
                prime_d = 1'b0;
                state_d = S_PRIME;
            end
            S_PRIME: begin
                prime_d = 1'b1;
                if (prime_q) state_d = S_RUN;
            end
            S_RUN: begin
                if (issue) begin
                    if (col_q == lcol_q) begin
                        col_d = '0;
                        if (row_q == lrow_q) state_d = S_DRAIN;
                        else                 row_d   = row_q + DIM_W'(1);
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            // next-count compare lets done land one cycle after the final result
            S_DRAIN: if (cnt_d >= total_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        refresh_d = (state_d == S_CFG);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            prime_q   <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            lrow_q    <= '0;
            lcol_q    <= '0;
            total_q   <= '0;
            cnt_q     <= '0;
            kern_q    <= '0;
            act_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prime_q   <= prime_d;
            row_q     <= row_d;
            col_q     <= col_d;
            lrow_q    <= lrow_d;
            lcol_q    <= lcol_d;
            total_q   <= total_d;
            cnt_q     <= cnt_d;
            kern_q    <= kern_d;
            act_q     <= act_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            refresh_q <= refresh_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign cfg_err           = err_q;
    assign arr.conf_refresh  = refresh_q;
    assign arr.kernel_height = kern_q;
    assign arr.kernel_width  = kern_q;
    assign arr.act_valid     = act_q;
    assign arr.win_row       = row_q;
    assign arr.win_col       = col_q;
    assign arr.window_valid  = issue;

`ifdef CNN_CONV_SEQ_PERF_EN
    logic [31:0] pcyc_q, pcyc_d, pstall_q, pstall_d;

    always_comb begin
        pcyc_d   = pcyc_q;
        pstall_d = pstall_q;
        if (accept) begin
            pcyc_d   = '0;
            pstall_d = '0;
        end else begin
            if ((state_q != S_IDLE) && (pcyc_q != '1)) pcyc_d = pcyc_q + 32'd1;
            if (in_run && arr.window_stall && (pstall_q != '1)) pstall_d = pstall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcyc_q   <= '0;
            pstall_q <= '0;
        end else begin
            pcyc_q   <= pcyc_d;
            pstall_q <= pstall_d;
        end
    end

    assign perf_cycles = pcyc_q;
    assign perf_stall  = pstall_q;
`endif
endmodule

// File: tb/tb_cnn_conv_seq.sv
// Directed bench for cnn_conv_seq: table of layer commands with hand-computed grids
// and completion cycles, plus reset and mid-layer reset sequences.
module tb_cnn_conv_seq;
    localparam int DIM_W = 10;
    localparam int KS    = 3;
    localparam int WS    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [DIM_W-1:0] cfg_height = '0;
    logic [DIM_W-1:0] cfg_width = '0;
    logic [KS-1:0]    cfg_kernel = '0;
    logic             cfg_act = 1'b0;
    logic             busy, done, cfg_err;
`ifdef CNN_CONV_SEQ_PERF_EN
    logic [31:0]      perf_cycles, perf_stall;
`endif

    cnn_conv_seq_if #(.DIM_W(DIM_W), .KERNEL_SIZE(KS), .WEIGHT_SIZE(WS)) arr ();

    cnn_conv_seq #(.DIM_W(DIM_W), .KERNEL_SIZE(KS), .WEIGHT_SIZE(WS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_height(cfg_height), .cfg_width(cfg_width), .cfg_kernel(cfg_kernel), .cfg_act(cfg_act),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .arr(arr)
`ifdef CNN_CONV_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // conv array model: two-stage result pipe that freezes while stalled
    logic [1:0] pipe;
    always @(posedge clk or posedge rst) begin
        if (rst) pipe <= 2'b00;
        else if (!arr.window_stall) pipe <= {pipe[0], arr.window_valid};
    end
    assign arr.conv_valid = {pipe[1], {(WS-1){1'b0}}};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // mode: 0 plain, 1 stall k=7..9, 2 src_ready on even k, 3 re-start at k=6
    typedef struct {
        int       h;
        int       w;
        logic [2:0] kern;
        logic     act;
        int       mode;
        logic     err;
        int       oh;
        int       ow;
        int       done_k;
    } vec_t;

    vec_t tv[10];

    int r_refresh_n, r_refresh_k, r_err_n, r_err_k, r_busy1, r_first_k, r_done_k;
    int r_busy_done, r_busy_after, r_done_after, r_nwin, r_bad, r_srow, r_scol, r_svalid;
    logic [31:0] r_pcyc, r_pstall;

    task automatic run_layer(input vec_t v);
        int er = 0;
        int ec = 0;
        int last_k;
        r_refresh_n = 0; r_refresh_k = -1; r_err_n = 0; r_err_k = -1; r_busy1 = -1;
        r_first_k = -1; r_done_k = -1; r_busy_done = -1; r_busy_after = -1; r_done_after = -1;
        r_nwin = 0; r_bad = 0; r_srow = -1; r_scol = -1; r_svalid = -1;
        r_pcyc = '0; r_pstall = '0;
        last_k = v.err ? 4 : 80;
        @(posedge clk); #1;
        start = 1'b1; cfg_height = DIM_W'(v.h); cfg_width = DIM_W'(v.w);
        cfg_kernel = v.kern; cfg_act = v.act;
        arr.src_ready = 1'b1; arr.window_stall = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            @(posedge clk); #1;
            start = (v.mode == 3 && k == 6);
            if (start) begin
                cfg_height = 3; cfg_width = 3; cfg_kernel = 3'b001; cfg_act = ~v.act;
            end
            arr.src_ready    = (v.mode == 2) ? (k % 2 == 0) : 1'b1;
            arr.window_stall = (v.mode == 1 && k >= 7 && k <= 9);
            @(negedge clk);
            if (arr.conf_refresh) begin r_refresh_n++; r_refresh_k = k; end
            if (cfg_err) begin r_err_n++; r_err_k = k; end
            if (k == 1) r_busy1 = busy;
            if (arr.window_valid) begin
                if (r_first_k < 0) r_first_k = k;
                if (arr.win_row != DIM_W'(er) || arr.win_col != DIM_W'(ec) ||
                    !arr.src_ready || arr.window_stall) r_bad++;
                r_nwin++;
                if (ec == v.ow - 1) begin ec = 0; er++; end
                else ec++;
            end
            if (v.mode == 1 && k == 8) begin
                r_srow = arr.win_row; r_scol = arr.win_col; r_svalid = arr.window_valid;
            end
            if (r_done_k >= 0) begin
                r_busy_after = busy; r_done_after = done;
`ifdef CNN_CONV_SEQ_PERF_EN
                r_pcyc = perf_cycles; r_pstall = perf_stall;
`endif
                break;
            end
            if (done) begin r_done_k = k; r_busy_done = busy; end
        end
        start = 1'b0; arr.src_ready = 1'b1; arr.window_stall = 1'b0;
    endtask

    task automatic check_layer(input string tag, input vec_t v);
        if (v.err) begin
            chk({tag, " cfg_err_k"}, r_err_k, 1);
            chk({tag, " cfg_err_n"}, r_err_n, 1);
            chk({tag, " busy"}, r_busy1, 0);
            chk({tag, " refresh_n"}, r_refresh_n, 0);
            chk({tag, " windows"}, r_nwin, 0);
        end else begin
            chk({tag, " cfg_err_n"}, r_err_n, 0);
            chk({tag, " refresh_k"}, r_refresh_k, 1);
            chk({tag, " refresh_n"}, r_refresh_n, 1);
            chk({tag, " busy_k1"}, r_busy1, 1);
            chk({tag, " first_win_k"}, r_first_k, 4);
            chk({tag, " windows"}, r_nwin, v.oh * v.ow);
            chk({tag, " order_bad"}, r_bad, 0);
            chk({tag, " done_k"}, r_done_k, v.done_k);
            chk({tag, " busy_at_done"}, r_busy_done, 1);
            chk({tag, " busy_after"}, r_busy_after, 0);
            chk({tag, " done_after"}, r_done_after, 0);
            chk({tag, " kernel_height"}, arr.kernel_height, v.kern);
            chk({tag, " kernel_width"}, arr.kernel_width, v.kern);
            chk({tag, " act_valid"}, arr.act_valid, v.act);
            if (v.mode == 1) begin
                chk({tag, " stall_row"}, r_srow, 1);
                chk({tag, " stall_col"}, r_scol, 0);
                chk({tag, " stall_valid"}, r_svalid, 0);
            end
`ifdef CNN_CONV_SEQ_PERF_EN
            chk({tag, " perf_cycles"}, r_pcyc, v.done_k);
            chk({tag, " perf_stall"}, r_pstall, (v.mode == 1) ? 3 : 0);
`endif
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {busy, done, cfg_err, arr.conf_refresh, arr.kernel_height, arr.kernel_width,
                arr.act_valid, arr.window_valid, arr.win_row, arr.win_col};
    endfunction

    initial begin
        int seen_done;
        arr.src_ready = 1'b1;
        arr.window_stall = 1'b0;

        //       h  w  kern    act  mode err  oh ow done_k
        tv[0] = '{5, 5, 3'b010, 1'b1, 0, 1'b0, 3, 3, 15};
        tv[1] = '{5, 5, 3'b010, 1'b0, 1, 1'b0, 3, 3, 18};
        tv[2] = '{5, 5, 3'b010, 1'b0, 2, 1'b0, 3, 3, 23};
        tv[3] = '{5, 5, 3'b010, 1'b1, 3, 1'b0, 3, 3, 15};
        tv[4] = '{1, 1, 3'b001, 1'b0, 0, 1'b0, 1, 1, 7};
        tv[5] = '{4, 6, 3'b010, 1'b1, 0, 1'b0, 2, 4, 14};
        tv[6] = '{7, 5, 3'b100, 1'b0, 0, 1'b0, 3, 1, 9};
        tv[7] = '{5, 5, 3'b011, 1'b0, 0, 1'b1, 0, 0, 0};
        tv[8] = '{2, 5, 3'b010, 1'b0, 0, 1'b1, 0, 0, 0};
        tv[9] = '{5, 4, 3'b100, 1'b0, 0, 1'b1, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_in_rst", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outs_after", all_outs(), 0);

        for (int i = 0; i < 10; i++) begin
            run_layer(tv[i]);
            check_layer($sformatf("v%0d", i), tv[i]);
        end

        // reset while issuing windows
        @(posedge clk); #1;
        start = 1'b1; cfg_height = 5; cfg_width = 5; cfg_kernel = 3'b010; cfg_act = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrun_issuing", arr.window_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_outs", all_outs(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy || arr.conf_refresh) seen_done++;
        end
        chk("post_rst_quiet", seen_done, 0);
        run_layer(tv[0]);
        check_layer("post_rst", tv[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
